clock_control: RTL

Generates the single-cycle CPU clock enable that paces every register stage (flip-flops, registers, counters) in the SAP-U datapath. It runs in free-run mode from a programmable divider or in manual mode, producing one pulse per clean step-button press. It stops permanently on the control unit's HLT signal. It sits directly upstream of all storage elements, whose load/update is qualified by `cpu_clk_en`.

---
 rtl/sap_pkg.sv | 12 +
 rtl/step_debouncer.sv | 61 ++++++
 rtl/clock_control.sv | 80 ++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-U definitions: clock-control state encoding and counter width.
package sap_pkg;

  localparam int CLK_CNT_W = 16;

  typedef enum logic [1:0] {
    CLK_RUN  = 2'd0,
    CLK_STEP = 2'd1,
    CLK_HALT = 2'd2
  } clk_state_t;

endpackage

// File: rtl/step_debouncer.sv
// Step-button conditioning: 2-flop synchronizer, optional stability filter
// (CLOCK_CONTROL_DEBOUNCE_EN), then a registered one-cycle rising-edge pulse.
module step_debouncer
  import sap_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  logic sync1, sync2, lvl, lvl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef CLOCK_CONTROL_DEBOUNCE_EN
  localparam logic [CLK_CNT_W-1:0] DEB_LAST = CLK_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CLK_CNT_W-1:0] cnt;

  // A new level is accepted only after it has held for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (sync2 == lvl) begin
      cnt <= '0;
    end else if (cnt == DEB_LAST) begin
      lvl <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic [CLK_CNT_W-1:0] unused_deb_cfg;
  assign unused_deb_cfg = CLK_CNT_W'(DEBOUNCE_CYCLES);
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_d       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      lvl_d       <= lvl;
      press_pulse <= lvl & ~lvl_d;
    end
  end

endmodule

// File: rtl/clock_control.sv
// SAP-U CPU clock-enable generator: free-run divider, manual step, sticky halt.
// Debouncer in the step path is enabled by CLOCK_CONTROL_DEBOUNCE_EN.
module clock_control
  import sap_pkg::*;
#(
  parameter int DIVIDE          = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run_mode,
  input  logic step_btn,
  input  logic halt,
  output logic cpu_clk_en,
  output logic cpu_clk_vis,
  output logic halted
);

  localparam logic [CLK_CNT_W-1:0] DIV_LAST = CLK_CNT_W'(DIVIDE - 1);

  clk_state_t           state;
  logic [CLK_CNT_W-1:0] count;
  logic                 press_pulse;
  logic                 div_hit;
  logic                 fire;

  step_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (step_btn),
    .press_pulse (press_pulse)
  );

  // The pulse follows the registered state, so a same-cycle run_mode drop
  // still emits it, while halt in the same cycle kills it.
  assign div_hit    = (state == CLK_RUN) && (count == DIV_LAST);
  assign fire       = !halt && (div_hit || ((state == CLK_STEP) && press_pulse));
  assign cpu_clk_en = fire;

  // Reset parks in STEP so the first post-reset edge picks RUN or STEP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLK_STEP;
      count       <= '0;
      cpu_clk_vis <= 1'b0;
      halted      <= 1'b0;
    end else begin
      cpu_clk_vis <= cpu_clk_vis ^ fire;
      unique case (state)
        CLK_RUN: begin
          if (halt) begin
            state  <= CLK_HALT;
            halted <= 1'b1;
            count  <= '0;
          end else if (!run_mode) begin
            state <= CLK_STEP;
            count <= '0;
          end else begin
            count <= div_hit ? '0 : count + 1'b1;
          end
        end
        CLK_STEP: begin
          count <= '0;
          if (halt) begin
            state  <= CLK_HALT;
            halted <= 1'b1;
          end else if (run_mode) begin
            state <= CLK_RUN;
          end
        end
        default: begin
          state  <= CLK_HALT;
          halted <= 1'b1;
          count  <= '0;
        end
      endcase
    end
  end

endmodule
